// File: rtl/board_pkg.sv
// ----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the connect-four board storage:
//   - default board dimensions (rows x columns)
//   - 2-bit cell codes for empty / player 1 / player 2
//   - drop-engine FSM state encoding
//   - NO_ROW marker reported for a rejected drop
//   - isPlayer helper that tells a legal piece code from an illegal one
// ----------------------------------------------------------------------------
package board_pkg;

   localparam int ROWS_DEFAULT = 6;
   localparam int COLS_DEFAULT = 7;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam logic [2:0] NO_ROW = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   // Only the two player codes may be dropped; 00 and 11 are rejected
   function automatic logic isPlayer(input logic [1:0] code);
      return (code == CELL_P1) || (code == CELL_P2);
   endfunction

endpackage

// File: rtl/board_memory_if.sv
// ----------------------------------------------------------------------------
// board_memory_if
// Bundles the board's read port, drop handshake, drop result and clear
// control into one connection.
//   slave  : the board itself (serves reads, accepts drops and clears)
//   master : whoever drives moves and reads the board
// Signals:
//   rd_row/rd_col -> rd_data          combinational cell read
//   drop_valid/drop_col/drop_player   drop request, drop_ready handshake
//   drop_done/drop_error/placed_*     result of the last resolved drop
//   clear -> busy                     board clear request and activity flag
//   board_full                        every column is at full height
// ----------------------------------------------------------------------------
interface board_memory_if;

   logic [2:0] rd_row;
   logic [2:0] rd_col;
   logic [1:0] rd_data;
   logic       drop_valid;
   logic [2:0] drop_col;
   logic [1:0] drop_player;
   logic       drop_ready;
   logic       drop_done;
   logic       drop_error;
   logic [2:0] placed_row;
   logic [2:0] placed_col;
   logic       clear;
   logic       busy;
   logic       board_full;

   modport slave (
      input  rd_row, rd_col, drop_valid, drop_col, drop_player, clear,
      output rd_data, drop_ready, drop_done, drop_error,
             placed_row, placed_col, busy, board_full
   );

   modport master (
      output rd_row, rd_col, drop_valid, drop_col, drop_player, clear,
      input  rd_data, drop_ready, drop_done, drop_error,
             placed_row, placed_col, busy, board_full
   );

endinterface

// File: rtl/board_column.sv
// ----------------------------------------------------------------------------
// board_column
// One column of the board: a stack of ROWS 2-bit cells plus the height
// counter that says where the next piece lands (row 0 is the bottom).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_rdRow           read row address; o_rdData is 00 for rows >= ROWS
//   i_push/i_pushData place a piece on top of the stack (ignored when full)
//   i_clearRowEn/i_clearRow  zero one row of the stack this cycle
//   i_clearHeight     drop the height counter back to zero
//   o_height, o_full  current fill height and full flag
// ----------------------------------------------------------------------------
module board_column
   import board_pkg::*;
#(
   parameter int ROWS = ROWS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] i_rdRow,
   output logic [1:0] o_rdData,
   input  logic       i_push,
   input  logic [1:0] i_pushData,
   input  logic       i_clearRowEn,
   input  logic [2:0] i_clearRow,
   input  logic       i_clearHeight,
   output logic [2:0] o_height,
   output logic       o_full
);

   localparam logic [2:0] FULL_HEIGHT = 3'(ROWS);

   logic [1:0] r_cells [ROWS];
   logic [2:0] r_height;

   assign o_height = r_height;
   assign o_full   = (r_height == FULL_HEIGHT);

   // Cell storage: a row being cleared wins over a push, and a push lands
   // in the row equal to the current height so pieces stack from the bottom
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) begin
            r_cells[r] <= CELL_EMPTY;
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (i_clearRowEn && (i_clearRow == 3'(r))) begin
               r_cells[r] <= CELL_EMPTY;
            end else if (i_push && !o_full && (r_height == 3'(r))) begin
               r_cells[r] <= i_pushData;
            end
         end
      end
   end

   // Height counter: cleared at the end of a board clear, otherwise bumped
   // on every push that actually found room
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_height <= 3'd0;
      end else if (i_clearHeight) begin
         r_height <= 3'd0;
      end else if (i_push && !o_full) begin
         r_height <= r_height + 3'd1;
      end
   end

   // Read mux: rows beyond the stack fall through to the empty default
   always_comb begin
      o_rdData = CELL_EMPTY;
      for (int r = 0; r < ROWS; r++) begin
         if (i_rdRow == 3'(r)) begin
            o_rdData = r_cells[r];
         end
      end
   end

endmodule

// File: rtl/board_memory.sv
// ----------------------------------------------------------------------------
// board_memory
// Connect-four board storage and drop engine. Holds ROWS x COLS 2-bit
// cells in COLS board_column instances, serves combinational reads with
// out-of-range addresses returning 00, places dropped pieces in the lowest
// empty row of a column, and clears the board one row per cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         board_memory_if slave: read port, drop handshake and
//               result, clear request, busy and board_full status
// ----------------------------------------------------------------------------
module board_memory
   import board_pkg::*;
#(
   parameter int ROWS = ROWS_DEFAULT,
   parameter int COLS = COLS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   board_memory_if.slave        bus
);

   localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
   localparam logic [2:0] COL_LIMIT = 3'(COLS);

   state_t     r_state;
   state_t     w_nextState;

   logic [2:0] r_col;
   logic [1:0] r_player;
   logic [2:0] r_clearRow;
   logic       r_dropDone;
   logic       r_dropError;
   logic [2:0] r_placedRow;
   logic [2:0] r_placedCol;

   logic [1:0]      w_colData   [COLS];
   logic [2:0]      w_colHeight [COLS];
   logic [COLS-1:0] w_colFull;
   logic [COLS-1:0] w_push;
   logic            w_clearRowEn;
   logic            w_clearHeight;
   logic            w_dropReady;
   logic            w_accept;
   logic            w_selFull;
   logic [2:0]      w_selHeight;
   logic            w_dropError;
   logic [1:0]      w_rdData;

   // One column instance per board column; all share the row address and
   // the clear controls, while pushes are steered to a single column
   for (genvar c = 0; c < COLS; c++) begin : g_col
      board_column #(
         .ROWS (ROWS)
      ) u_column (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_rdRow       (bus.rd_row),
         .o_rdData      (w_colData[c]),
         .i_push        (w_push[c]),
         .i_pushData    (r_player),
         .i_clearRowEn  (w_clearRowEn),
         .i_clearRow    (r_clearRow),
         .i_clearHeight (w_clearHeight),
         .o_height      (w_colHeight[c]),
         .o_full        (w_colFull[c])
      );
   end

   // Column select for reads; a column address past the board matches no
   // instance and so reads as empty, which keeps wrapped coordinates from
   // forming false lines in the checker
   always_comb begin
      w_rdData = CELL_EMPTY;
      for (int c = 0; c < COLS; c++) begin
         if (bus.rd_col == 3'(c)) begin
            w_rdData = w_colData[c];
         end
      end
   end

   // Status of the column latched for the pending drop
   always_comb begin
      w_selFull   = 1'b0;
      w_selHeight = 3'd0;
      for (int c = 0; c < COLS; c++) begin
         if (r_col == 3'(c)) begin
            w_selFull   = w_colFull[c];
            w_selHeight = w_colHeight[c];
         end
      end
   end

   // A drop is rejected for a column off the board, a full column, or an
   // illegal piece code; rejected drops leave the board untouched
   assign w_dropError = (r_col >= COL_LIMIT) || w_selFull || !isPlayer(r_player);
   assign w_accept    = bus.drop_valid && w_dropReady;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: clear beats a drop offered in the same cycle, a
   // drop resolves in one cycle, and a clear walks every row once
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.clear) begin
               w_nextState = ST_CLEAR;
            end else if (w_accept) begin
               w_nextState = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_nextState = ST_IDLE;
         end
         ST_CLEAR: begin
            if (r_clearRow == LAST_ROW) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Output/control decode. drop_ready is also held low during the
   // drop_done cycle so a requester sees one result per accepted drop
   // before the next one can be taken
   always_comb begin
      w_push        = '0;
      w_clearRowEn  = 1'b0;
      w_clearHeight = 1'b0;
      w_dropReady   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_dropReady = !bus.clear && !r_dropDone;
         end
         ST_WRITE: begin
            for (int c = 0; c < COLS; c++) begin
               if ((r_col == 3'(c)) && !w_dropError) begin
                  w_push[c] = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            w_clearRowEn  = 1'b1;
            w_clearHeight = (r_clearRow == LAST_ROW);
         end
         default: begin
            w_dropReady = 1'b0;
         end
      endcase
   end

   // Request capture, clear row counter and drop result registers. The
   // result fields hold their value until the next drop resolves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= 3'd0;
         r_player    <= CELL_EMPTY;
         r_clearRow  <= 3'd0;
         r_dropDone  <= 1'b0;
         r_dropError <= 1'b0;
         r_placedRow <= 3'd0;
         r_placedCol <= 3'd0;
      end else begin
         r_dropDone <= 1'b0;
         if ((r_state == ST_IDLE) && bus.clear) begin
            r_clearRow <= 3'd0;
         end else if (w_accept) begin
            r_col    <= bus.drop_col;
            r_player <= bus.drop_player;
         end
         if (r_state == ST_CLEAR) begin
            r_clearRow <= r_clearRow + 3'd1;
         end
         if (r_state == ST_WRITE) begin
            r_dropDone  <= 1'b1;
            r_dropError <= w_dropError;
            r_placedRow <= w_dropError ? NO_ROW : w_selHeight;
            r_placedCol <= r_col;
         end
      end
   end

   assign bus.rd_data    = w_rdData;
   assign bus.drop_ready = w_dropReady;
   assign bus.drop_done  = r_dropDone;
   assign bus.drop_error = r_dropError;
   assign bus.placed_row = r_placedRow;
   assign bus.placed_col = r_placedCol;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.board_full = &w_colFull;

endmodule

// File: tb/tb_board_memory.sv
// ----------------------------------------------------------------------------
// tb_board_memory
// Self-checking bench for board_memory on a 6 x 7 board. Expected drop
// results are queued when a drop is driven and compared when drop_done
// fires; board contents are compared against a reference grid.
// ----------------------------------------------------------------------------
module tb_board_memory;
   import board_pkg::*;

   typedef struct packed {
      logic       err;
      logic [2:0] row;
      logic [2:0] col;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   exp_t       expQ [$];
   logic [1:0] model [6][7];
   int         heights [7];

   board_memory_if bus();

   board_memory #(
      .ROWS (6),
      .COLS (7)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Scoreboard: every drop_done must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.drop_done === 1'b1) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_done: drop_done=1 with no accepted drop pending");
         end else begin
            e = expQ.pop_front();
            total++;
            if (bus.drop_error !== e.err) begin
               bad++;
               $display("[TB] FAIL drop_error: got %b want %b (col %0d)", bus.drop_error, e.err, e.col);
            end
            total++;
            if (bus.placed_row !== e.row) begin
               bad++;
               $display("[TB] FAIL placed_row: got %0d want %0d (col %0d)", bus.placed_row, e.row, e.col);
            end
            total++;
            if (bus.placed_col !== e.col) begin
               bad++;
               $display("[TB] FAIL placed_col: got %0d want %0d", bus.placed_col, e.col);
            end
         end
      end
   end

   // Reference board reset
   task automatic clearModel();
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            model[r][c] = CELL_EMPTY;
         end
      end
      for (int c = 0; c < 7; c++) begin
         heights[c] = 0;
      end
   endtask

   function automatic logic [1:0] modelCell(input int r, input int c);
      logic [1:0] v;
      v = CELL_EMPTY;
      if (r < 6 && c < 7) begin
         v = model[r][c];
      end
      return v;
   endfunction

   task automatic readCell(input int r, input int c, output logic [1:0] d);
      bus.rd_row = 3'(r);
      bus.rd_col = 3'(c);
      #1;
      d = bus.rd_data;
   endtask

   // Drive one drop, queue its expected result, and check handshake timing
   task automatic applyDrop(input logic [2:0] col, input logic [1:0] player);
      exp_t e;
      int   waited;
      logic err;
      waited = 0;
      @(negedge clk);
      while (bus.drop_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (bus.drop_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_timeout: drop_ready=%b want 1 within 20 cycles", bus.drop_ready);
         return;
      end
      if (col >= 3'd7) begin
         err = 1'b1;
      end else begin
         err = (heights[col] == 6) || !(player == CELL_P1 || player == CELL_P2);
      end
      e.err = err;
      e.col = col;
      e.row = err ? NO_ROW : 3'(heights[col]);
      if (!err) begin
         model[heights[col]][col] = player;
         heights[col]++;
      end
      expQ.push_back(e);
      bus.drop_valid  = 1'b1;
      bus.drop_col    = col;
      bus.drop_player = player;
      @(posedge clk);
      #1;
      bus.drop_valid = 1'b0;
      total++;
      if (bus.drop_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ready_in_write: got %b want 0", bus.drop_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.drop_done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL done_latency: drop_done=%b want 1 one cycle after accept", bus.drop_done);
      end
      total++;
      if (bus.drop_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ready_in_done: got %b want 0", bus.drop_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.drop_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL done_width: drop_done=%b want 0", bus.drop_done);
      end
      total++;
      if (bus.drop_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_return: got %b want 1", bus.drop_ready);
      end
   endtask

   task automatic test_reset();
      logic [1:0] got;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      total++;
      if (bus.drop_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.drop_done); end
      total++;
      if (bus.drop_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", bus.drop_error); end
      total++;
      if (bus.placed_row !== 3'd0) begin bad++; $display("[TB] FAIL reset_row: got %0d want 0", bus.placed_row); end
      total++;
      if (bus.placed_col !== 3'd0) begin bad++; $display("[TB] FAIL reset_col: got %0d want 0", bus.placed_col); end
      total++;
      if (bus.drop_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", bus.drop_ready); end
      total++;
      if (bus.board_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", bus.board_full); end
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            readCell(r, c, got);
            total++;
            if (got !== 2'b00) begin
               bad++;
               $display("[TB] FAIL reset_cell(%0d,%0d): got %b want 00", r, c, got);
            end
         end
      end
   endtask

   task automatic test_stack_col3();
      logic [1:0] got;
      for (int i = 0; i < 4; i++) begin
         applyDrop(3'd3, CELL_P1);
      end
      readCell(3, 3, got);
      total++;
      if (got !== CELL_P1) begin bad++; $display("[TB] FAIL cell_3_3: got %b want 01", got); end
      readCell(4, 3, got);
      total++;
      if (got !== CELL_EMPTY) begin bad++; $display("[TB] FAIL cell_4_3: got %b want 00", got); end
   endtask

   task automatic test_overflow_col0();
      logic [1:0] got;
      for (int i = 0; i < 7; i++) begin
         applyDrop(3'd0, CELL_P2);
      end
      readCell(5, 0, got);
      total++;
      if (got !== CELL_P2) begin bad++; $display("[TB] FAIL cell_5_0: got %b want 10", got); end
   endtask

   task automatic test_bad_drops();
      logic [1:0] got;
      applyDrop(3'd7, CELL_P1);
      applyDrop(3'd1, 2'b11);
      applyDrop(3'd1, CELL_EMPTY);
      readCell(0, 1, got);
      total++;
      if (got !== CELL_EMPTY) begin bad++; $display("[TB] FAIL bad_player_cell: got %b want 00", got); end
   endtask

   task automatic test_fill_and_clear();
      logic [1:0] got;
      int         busyCycles;
      int         turn;
      turn = 0;
      for (int c = 0; c < 7; c++) begin
         while (heights[c] < 6) begin
            applyDrop(3'(c), (turn % 2 == 0) ? CELL_P1 : CELL_P2);
            turn++;
         end
      end
      total++;
      if (bus.board_full !== 1'b1) begin bad++; $display("[TB] FAIL full_flag: got %b want 1", bus.board_full); end
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            readCell(r, c, got);
            total++;
            if (got !== modelCell(r, c)) begin
               bad++;
               $display("[TB] FAIL full_cell(%0d,%0d): got %b want %b", r, c, got, modelCell(r, c));
            end
         end
      end
      readCell(7, 2, got);
      total++;
      if (got !== 2'b00) begin bad++; $display("[TB] FAIL oor_row7: got %b want 00", got); end
      readCell(1, 7, got);
      total++;
      if (got !== 2'b00) begin bad++; $display("[TB] FAIL oor_col7: got %b want 00", got); end

      @(negedge clk);
      bus.clear       = 1'b1;
      bus.drop_valid  = 1'b1;
      bus.drop_col    = 3'd0;
      bus.drop_player = CELL_P1;
      @(posedge clk);
      #1;
      bus.clear      = 1'b0;
      bus.drop_valid = 1'b0;
      busyCycles = 0;
      while (bus.busy === 1'b1 && busyCycles < 20) begin
         busyCycles++;
         total++;
         if (bus.drop_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_in_clear: got %b want 0", bus.drop_ready); end
         @(posedge clk);
         #1;
      end
      total++;
      if (busyCycles != 6) begin bad++; $display("[TB] FAIL clear_cycles: got %0d want 6", busyCycles); end
      total++;
      if (bus.drop_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_clear: got %b want 1", bus.drop_ready); end
      clearModel();
      total++;
      if (bus.board_full !== 1'b0) begin bad++; $display("[TB] FAIL full_after_clear: got %b want 0", bus.board_full); end
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            readCell(r, c, got);
            total++;
            if (got !== 2'b00) begin
               bad++;
               $display("[TB] FAIL cleared_cell(%0d,%0d): got %b want 00", r, c, got);
            end
         end
      end
      applyDrop(3'd2, CELL_P1);
   endtask

   task automatic test_reset_midop();
      logic [1:0] got;
      applyDrop(3'd4, CELL_P2);
      @(negedge clk);
      bus.drop_valid  = 1'b1;
      bus.drop_col    = 3'd4;
      bus.drop_player = CELL_P1;
      @(posedge clk);
      #1;
      bus.drop_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_write_busy: got %b want 0", bus.busy); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            readCell(r, c, got);
            total++;
            if (got !== 2'b00) begin
               bad++;
               $display("[TB] FAIL write_reset_cell(%0d,%0d): got %b want 00", r, c, got);
            end
         end
      end

      for (int i = 0; i < 3; i++) begin
         applyDrop(3'd5, CELL_P1);
      end
      @(negedge clk);
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_clear_busy: got %b want 0", bus.busy); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            readCell(r, c, got);
            total++;
            if (got !== 2'b00) begin
               bad++;
               $display("[TB] FAIL clear_reset_cell(%0d,%0d): got %b want 00", r, c, got);
            end
         end
      end
      applyDrop(3'd5, CELL_P2);
   endtask

   // Test sequence
   initial begin
      rst_n           = 1'b0;
      bus.rd_row      = 3'd0;
      bus.rd_col      = 3'd0;
      bus.drop_valid  = 1'b0;
      bus.drop_col    = 3'd0;
      bus.drop_player = CELL_EMPTY;
      bus.clear       = 1'b0;
      clearModel();

      $display("[TB] reset");
      test_reset();
      $display("[TB] stack column 3");
      test_stack_col3();
      $display("[TB] overflow column 0");
      test_overflow_col0();
      $display("[TB] rejected drops");
      test_bad_drops();
      $display("[TB] fill and clear");
      test_fill_and_clear();
      $display("[TB] reset during write and clear");
      test_reset_midop();

      repeat (3) @(posedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL pending_results: %0d drop results never arrived, want 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
